// File: rtl/utils_pkg.sv
// Shared types and constants for the load/store unit: op encodings, trap info,
// FSM states and the data-bus request/response bundles.
package utils_pkg;

  localparam int unsigned XLEN = 32;

  // Machine trap-cause codes for the faults this unit reports.
  localparam logic [3:0] CAUSE_LD_MISALIGNED = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS     = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS     = 4'd7;

  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_t;

  typedef enum logic [2:0] {
    LSU_B  = 3'd0,
    LSU_H  = 3'd1,
    LSU_W  = 3'd2,
    LSU_BU = 3'd3,
    LSU_HU = 3'd4
  } lsu_w_t;

  typedef struct packed {
    lsu_t              op_typ;
    lsu_w_t            width;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } s_lsu_op_t;

  typedef struct packed {
    logic              active;
    logic [XLEN-1:0]   mtval;
  } s_trap_info_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } lsu_fsm_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    logic              we;
    logic [XLEN-1:0]   wdata;
    logic [3:0]        wstrb;
  } s_dbus_req_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rdata;
    logic              err;
  } s_dbus_rsp_t;

  function automatic logic misaligned(input lsu_w_t width, input logic [1:0] off);
    case (width)
      LSU_H, LSU_HU: return off[0];
      LSU_W:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes and lane replication,
// load lane selection with sign or zero extension.
module lsu_align
  import utils_pkg::*;
(
  input  lsu_w_t      width_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    wstrb_o   = 4'hF;
    wdata_o   = st_data_i;
    shifted   = ld_raw_i >> {off_i, 3'b000};
    ld_data_o = shifted;

    case (width_i)
      LSU_B, LSU_BU: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      LSU_H, LSU_HU: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase

    case (width_i)
      LSU_B:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_BU:  ld_data_o = {24'h0, shifted[7:0]};
      LSU_H:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_HU:  ld_data_o = {16'h0, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one memory op at a time on a single-outstanding
// valid/ready data bus, stalls execute until the response, reports faults.
module lsu
  import utils_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  s_lsu_op_t               lsu_i,
  input  logic [4:0]              rd_addr_i,
  output logic                    lsu_bp_o,
  output logic                    dbus_req_valid_o,
  input  logic                    dbus_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   dbus_req_addr_o,
  output logic                    dbus_req_we_o,
  output logic [DATA_WIDTH-1:0]   dbus_req_wdata_o,
  output logic [3:0]              dbus_req_wstrb_o,
  input  logic                    dbus_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   dbus_rsp_rdata_i,
  input  logic                    dbus_rsp_err_i,
  output logic                    dbus_rsp_ready_o,
  output logic                    ld_valid_o,
  output logic [DATA_WIDTH-1:0]   ld_rdata_o,
  output logic [4:0]              ld_rd_o,
  output s_trap_info_t            lsu_trap_ld_o,
  output s_trap_info_t            lsu_trap_st_o
);

  lsu_fsm_t    state_q, state_d;
  s_lsu_op_t   op_q, op_d;
  logic [4:0]  rd_q, rd_d;

  s_lsu_op_t   cur_op;
  s_dbus_req_t req;
  s_dbus_rsp_t rsp;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;

  // In IDLE the request is formed straight from execute; afterwards from the captured op.
  assign cur_op = (state_q == S_IDLE) ? lsu_i : op_q;
  assign rsp    = '{valid: dbus_rsp_valid_i, rdata: dbus_rsp_rdata_i, err: dbus_rsp_err_i};

  lsu_align u_align (
    .width_i   (cur_op.width),
    .off_i     (cur_op.addr[1:0]),
    .st_data_i (cur_op.wdata),
    .ld_raw_i  (rsp.rdata),
    .wstrb_o   (lane_strb),
    .wdata_o   (lane_wdata),
    .ld_data_o (lane_ld)
  );

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    rd_d             = rd_q;
    req              = '0;
    lsu_bp_o         = 1'b0;
    dbus_rsp_ready_o = 1'b0;
    ld_valid_o       = 1'b0;
    ld_rdata_o       = '0;
    ld_rd_o          = '0;
    lsu_trap_ld_o    = '0;
    lsu_trap_st_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (lsu_i.op_typ != LSU_NONE) begin
          if (misaligned(lsu_i.width, lsu_i.addr[1:0])) begin
            lsu_trap_ld_o = '{active: lsu_i.op_typ == LSU_LOAD,  mtval: lsu_i.addr};
            lsu_trap_st_o = '{active: lsu_i.op_typ == LSU_STORE, mtval: lsu_i.addr};
          end else begin
            req.valid = 1'b1;
            lsu_bp_o  = 1'b1;
            op_d      = lsu_i;
            rd_d      = rd_addr_i;
            state_d   = dbus_req_ready_i ? S_RSP : S_REQ;
          end
        end
      end
      S_REQ: begin
        req.valid = 1'b1;
        lsu_bp_o  = 1'b1;
        if (dbus_req_ready_i) state_d = S_RSP;
      end
      S_RSP: begin
        dbus_rsp_ready_o = 1'b1;
        lsu_bp_o         = !rsp.valid;
        if (rsp.valid) begin
          state_d = S_IDLE;
          if (rsp.err) begin
            lsu_trap_ld_o = '{active: op_q.op_typ == LSU_LOAD,  mtval: op_q.addr};
            lsu_trap_st_o = '{active: op_q.op_typ == LSU_STORE, mtval: op_q.addr};
          end else if (op_q.op_typ == LSU_LOAD) begin
            ld_valid_o = 1'b1;
            ld_rdata_o = lane_ld;
            ld_rd_o    = rd_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (req.valid) begin
      req.addr  = {cur_op.addr[31:2], 2'b00};
      req.we    = cur_op.op_typ == LSU_STORE;
      req.wdata = lane_wdata;
      req.wstrb = req.we ? lane_strb : 4'h0;
    end

    // Reset forces every output quiet even while execute still presents an op.
    if (rst) begin
      req              = '0;
      lsu_bp_o         = 1'b0;
      dbus_rsp_ready_o = 1'b0;
      ld_valid_o       = 1'b0;
      ld_rdata_o       = '0;
      ld_rd_o          = '0;
      lsu_trap_ld_o    = '0;
      lsu_trap_st_o    = '0;
    end
  end

  assign dbus_req_valid_o = req.valid;
  assign dbus_req_addr_o  = req.addr;
  assign dbus_req_we_o    = req.we;
  assign dbus_req_wdata_o = req.wdata;
  assign dbus_req_wstrb_o = req.wstrb;

  // NOTE: sequential state uses non-blocking assignments; the synchronous reset lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized ops, with a
// scoreboard of expected load results and traps checked by a separate monitor.
module tb_lsu;
  import utils_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  s_lsu_op_t    lsu_i;
  logic [4:0]   rd_addr_i;
  logic         lsu_bp_o;
  logic         dbus_req_valid_o;
  logic         dbus_req_ready_i;
  logic [31:0]  dbus_req_addr_o;
  logic         dbus_req_we_o;
  logic [31:0]  dbus_req_wdata_o;
  logic [3:0]   dbus_req_wstrb_o;
  logic         dbus_rsp_valid_i;
  logic [31:0]  dbus_rsp_rdata_i;
  logic         dbus_rsp_err_i;
  logic         dbus_rsp_ready_o;
  logic         ld_valid_o;
  logic [31:0]  ld_rdata_o;
  logic [4:0]   ld_rd_o;
  s_trap_info_t lsu_trap_ld_o;
  s_trap_info_t lsu_trap_st_o;

  lsu dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_i            (lsu_i),
    .rd_addr_i        (rd_addr_i),
    .lsu_bp_o         (lsu_bp_o),
    .dbus_req_valid_o (dbus_req_valid_o),
    .dbus_req_ready_i (dbus_req_ready_i),
    .dbus_req_addr_o  (dbus_req_addr_o),
    .dbus_req_we_o    (dbus_req_we_o),
    .dbus_req_wdata_o (dbus_req_wdata_o),
    .dbus_req_wstrb_o (dbus_req_wstrb_o),
    .dbus_rsp_valid_i (dbus_rsp_valid_i),
    .dbus_rsp_rdata_i (dbus_rsp_rdata_i),
    .dbus_rsp_err_i   (dbus_rsp_err_i),
    .dbus_rsp_ready_o (dbus_rsp_ready_o),
    .ld_valid_o       (ld_valid_o),
    .ld_rdata_o       (ld_rdata_o),
    .ld_rd_o          (ld_rd_o),
    .lsu_trap_ld_o    (lsu_trap_ld_o),
    .lsu_trap_st_o    (lsu_trap_st_o)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {E_LD, E_TLD, E_TST} exp_kind_t;
  typedef struct {
    exp_kind_t   kind;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes decides alignment, strobes, lanes.
  function automatic int size_of(input lsu_w_t w);
    if (w == LSU_W) return 4;
    if (w == LSU_H || w == LSU_HU) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] model_strb(input lsu_w_t w, input logic [31:0] addr);
    int sz = size_of(w);
    int lanes = (1 << sz) - 1;
    return 4'(lanes << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input lsu_w_t w, input logic [31:0] d);
    logic [31:0] r;
    int sz = size_of(w);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input lsu_w_t w, input logic [31:0] addr,
                                             input logic [31:0] raw);
    logic [31:0] v;
    int sz = size_of(w);
    v = raw >> (8 * (addr % 4));
    if (sz == 1) v = v & 32'hFF;
    if (sz == 2) v = v & 32'hFFFF;
    if (w == LSU_B && v >= 32'h80) v = v - 32'h100;
    if (w == LSU_H && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  // Monitor: any load result or trap must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ld_valid_o || lsu_trap_ld_o.active || lsu_trap_st_o.active) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_ld_valid", 32'(ld_valid_o), 32'(e.kind == E_LD));
        check("mon_trap_ld", 32'(lsu_trap_ld_o.active), 32'(e.kind == E_TLD));
        check("mon_trap_st", 32'(lsu_trap_st_o.active), 32'(e.kind == E_TST));
        if (e.kind == E_LD) begin
          check("mon_ld_rdata", ld_rdata_o, e.data);
          check("mon_ld_rd", 32'(ld_rd_o), 32'(e.rd));
        end else if (e.kind == E_TLD) begin
          check("mon_ld_mtval", lsu_trap_ld_o.mtval, e.data);
        end else begin
          check("mon_st_mtval", lsu_trap_st_o.mtval, e.data);
        end
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    lsu_i = '{op_typ: LSU_NONE, width: lsu_w_t'(3'($urandom_range(0, 4))),
              addr: $urandom, wdata: $urandom};
    dbus_req_ready_i = 1'($urandom);
    dbus_rsp_valid_i = 1'b0;
    dbus_rsp_err_i   = 1'b0;
    dbus_rsp_rdata_i = $urandom;
    @(negedge clk);
    check("idle_bp", 32'(lsu_bp_o), 32'd0);
    check("idle_req_valid", 32'(dbus_req_valid_o), 32'd0);
  endtask

  task automatic run_op(input lsu_t typ, input lsu_w_t w, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int rwait, input int swait, input bit err,
                        input logic [31:0] rdata);
    exp_t e;
    bit   mis = (addr % size_of(w)) != 0;
    @(posedge clk); #1;
    lsu_i            = '{op_typ: typ, width: w, addr: addr, wdata: wdata};
    rd_addr_i        = rd;
    dbus_req_ready_i = (rwait == 0);
    dbus_rsp_valid_i = 1'b0;
    dbus_rsp_err_i   = 1'b0;
    if (mis) begin
      e = '{kind: (typ == LSU_LOAD) ? E_TLD : E_TST, data: addr, rd: 5'd0};
      sb.push_back(e);
      @(negedge clk);
      check("mis_bp", 32'(lsu_bp_o), 32'd0);
      check("mis_req_valid", 32'(dbus_req_valid_o), 32'd0);
    end else begin
      for (int n = 0; n <= rwait; n++) begin
        if (n > 0) begin
          @(posedge clk); #1;
          dbus_req_ready_i = (n == rwait);
          dbus_rsp_valid_i = 1'($urandom);
        end
        @(negedge clk);
        check("req_valid", 32'(dbus_req_valid_o), 32'd1);
        check("req_bp", 32'(lsu_bp_o), 32'd1);
        check("req_rsp_ready", 32'(dbus_rsp_ready_o), 32'd0);
        check("req_addr", dbus_req_addr_o, addr & 32'hFFFF_FFFC);
        check("req_we", 32'(dbus_req_we_o), 32'(typ == LSU_STORE));
        check("req_wstrb", 32'(dbus_req_wstrb_o),
              (typ == LSU_STORE) ? 32'(model_strb(w, addr)) : 32'd0);
        if (typ == LSU_STORE) check("req_wdata", dbus_req_wdata_o, model_wdata(w, wdata));
      end
      for (int k = 0; k <= swait; k++) begin
        @(posedge clk); #1;
        dbus_req_ready_i = 1'($urandom);
        dbus_rsp_valid_i = (k == swait);
        dbus_rsp_err_i   = (k == swait) ? err : 1'($urandom);
        dbus_rsp_rdata_i = (k == swait) ? rdata : $urandom;
        if (k == swait) begin
          if (err) begin
            e = '{kind: (typ == LSU_LOAD) ? E_TLD : E_TST, data: addr, rd: 5'd0};
            sb.push_back(e);
          end else if (typ == LSU_LOAD) begin
            e = '{kind: E_LD, data: model_load(w, addr, rdata), rd: rd};
            sb.push_back(e);
          end
        end
        @(negedge clk);
        check("rsp_ready", 32'(dbus_rsp_ready_o), 32'd1);
        check("rsp_req_valid", 32'(dbus_req_valid_o), 32'd0);
        check("rsp_bp", 32'(lsu_bp_o), 32'(k != swait));
      end
    end
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    lsu_i            = '{op_typ: LSU_NONE, width: LSU_W, addr: 32'h0, wdata: 32'h0};
    rd_addr_i        = 5'd0;
    dbus_req_ready_i = 1'b0;
    dbus_rsp_valid_i = 1'b0;
    dbus_rsp_rdata_i = 32'h0;
    dbus_rsp_err_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_bp", 32'(lsu_bp_o), 32'd0);
    check("reset_req_valid", 32'(dbus_req_valid_o), 32'd0);
    check("reset_rsp_ready", 32'(dbus_rsp_ready_o), 32'd0);
    check("reset_ld_valid", 32'(ld_valid_o), 32'd0);
    check("reset_trap_ld", 32'(lsu_trap_ld_o.active), 32'd0);
    check("reset_trap_st", 32'(lsu_trap_st_o.active), 32'd0);

    // Directed cases.
    run_op(LSU_LOAD,  LSU_W,  32'h100, 32'h0,        5'd3,  0, 0, 1'b0, 32'hDEADBEEF);
    run_op(LSU_LOAD,  LSU_B,  32'h103, 32'h0,        5'd4,  0, 0, 1'b0, 32'h80112233);
    run_op(LSU_LOAD,  LSU_BU, 32'h103, 32'h0,        5'd5,  1, 2, 1'b0, 32'h80112233);
    run_op(LSU_STORE, LSU_H,  32'h202, 32'h0000ABCD, 5'd0,  0, 1, 1'b0, 32'h0);
    run_op(LSU_LOAD,  LSU_W,  32'h102, 32'h0,        5'd6,  0, 0, 1'b0, 32'h0);
    run_op(LSU_STORE, LSU_W,  32'h300, 32'h12345678, 5'd0,  3, 0, 1'b1, 32'h0);
    run_op(LSU_LOAD,  LSU_H,  32'h106, 32'h0,        5'd9,  0, 0, 1'b0, 32'h8001_7FFF);
    run_op(LSU_LOAD,  LSU_HU, 32'h105, 32'h0,        5'd9,  0, 0, 1'b0, 32'h0);
    run_op(LSU_LOAD,  LSU_H,  32'h100, 32'h0,        5'd1,  2, 1, 1'b1, 32'hFFFF_FFFF);

    // Reset while waiting for the response; the late response must vanish.
    @(posedge clk); #1;
    lsu_i            = '{op_typ: LSU_LOAD, width: LSU_W, addr: 32'h400, wdata: 32'h0};
    rd_addr_i        = 5'd7;
    dbus_req_ready_i = 1'b1;
    @(posedge clk); #1;
    dbus_req_ready_i = 1'b0;
    @(negedge clk);
    check("rst6_rsp_ready_before", 32'(dbus_rsp_ready_o), 32'd1);
    @(posedge clk); #1;
    rst   = 1'b1;
    lsu_i = '{op_typ: LSU_NONE, width: LSU_W, addr: 32'h0, wdata: 32'h0};
    @(posedge clk); #1;
    rst              = 1'b0;
    dbus_rsp_valid_i = 1'b1;
    dbus_rsp_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    check("rst6_bp", 32'(lsu_bp_o), 32'd0);
    check("rst6_req_valid", 32'(dbus_req_valid_o), 32'd0);
    check("rst6_rsp_ready", 32'(dbus_rsp_ready_o), 32'd0);
    check("rst6_ld_valid", 32'(ld_valid_o), 32'd0);
    idle_cycle();

    // Randomized ops.
    for (int i = 0; i < 200; i++) begin
      lsu_t        typ  = ($urandom_range(0, 1) == 0) ? LSU_LOAD : LSU_STORE;
      lsu_w_t      w    = lsu_w_t'(3'($urandom_range(0, 4)));
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size_of(w) - 1);
      if (typ == LSU_STORE && (w == LSU_BU || w == LSU_HU)) w = (w == LSU_BU) ? LSU_B : LSU_H;
      run_op(typ, w, addr, $urandom, 5'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
